// File: rtl/control_axil_regs.sv
// AXI4-Lite register bank for the board control bus.
// Holds the LED and seven-segment value registers, a scratch word, sticky
// error flags with write-1-to-clear, and returns the synchronised switch state.
module control_axil_regs #(
  parameter logic [31:0] ID_VALUE       = 32'hB3A5_0001,
  parameter int          ADDR_W         = 8,
  parameter int          SW_SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] control_awaddr,
  input  logic              control_awvalid,
  output logic              control_awready,
  input  logic [31:0]       control_wdata,
  input  logic              control_wvalid,
  output logic              control_wready,
  output logic [1:0]        control_bresp,
  output logic              control_bvalid,
  input  logic              control_bready,
  input  logic [ADDR_W-1:0] control_araddr,
  input  logic              control_arvalid,
  output logic              control_arready,
  output logic [31:0]       control_rdata,
  output logic [1:0]        control_rresp,
  output logic              control_rvalid,
  input  logic              control_rready,
  input  logic [15:0]       sw,
  input  logic              flash_error,
  input  logic              uart_error,
  output logic [15:0]       led,
  output logic [15:0]       seg_value
);

  localparam int IDX_W = ADDR_W - 2;

  // Word indices of the mapped registers (byte offset / 4)
  localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_LED     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_SW      = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_SEG     = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(5);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t            w_state;
  r_state_t            r_state;

  logic                awready_reg, wready_reg, bvalid_reg;
  logic [1:0]          bresp_reg;
  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   awaddr_reg;
  logic [31:0]         wdata_reg;

  logic                arready_reg, rvalid_reg;
  logic [1:0]          rresp_reg;
  logic [31:0]         rdata_reg;

  logic [15:0]         led_reg, seg_reg;
  logic [31:0]         scratch_reg;
  logic [1:0]          status_reg;
  logic [SW_SYNC_STAGES*16-1:0] sw_sync;
  logic [15:0]         sw_synced;

  logic                aw_hs, w_hs, ar_hs, wr_fire, wr_mapped, rd_err;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic [31:0]         rd_word;
  logic [1:0]          status_clr;
  logic                unused_addr_bits;

  // Byte-lane bits of the addresses are not decoded
  assign unused_addr_bits = &{1'b0, awaddr_reg[1:0], control_araddr[1:0]};

  assign aw_hs     = control_awvalid & awready_reg;
  assign w_hs      = control_wvalid & wready_reg;
  assign ar_hs     = control_arvalid & arready_reg;
  assign wr_idx    = awaddr_reg[ADDR_W-1:2];
  assign rd_idx    = control_araddr[ADDR_W-1:2];
  assign wr_fire   = (w_state == W_IDLE) & aw_held & w_held;
  assign wr_mapped = (wr_idx <= IDX_SCRATCH);
  assign sw_synced = sw_sync[SW_SYNC_STAGES*16-1 -: 16];

  // Switch synchroniser: a shift chain, newest sample enters at the bottom
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sw_sync <= '0;
    else if (SW_SYNC_STAGES > 1) sw_sync <= {sw_sync[(SW_SYNC_STAGES-1)*16-1:0], sw};
    else sw_sync <= sw_sync ^ sw_sync ^ {(SW_SYNC_STAGES*16/16){sw}};
  end

  // Read data mux, evaluated on the live AR address and captured at the handshake
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      IDX_ID:      rd_word = ID_VALUE;
      IDX_LED:     rd_word = {16'h0000, led_reg};
      IDX_SW:      rd_word = {16'h0000, sw_synced};
      IDX_SEG:     rd_word = {16'h0000, seg_reg};
      IDX_STATUS:  rd_word = {30'h0, status_reg};
      IDX_SCRATCH: rd_word = scratch_reg;
      default:     rd_err  = 1'b1;
    endcase
  end

  // Write channel: collect AW and W in any order, then update and respond
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state     <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            w_state     <= W_RESP;
          end else begin
            if (aw_hs) begin
              awaddr_reg <= control_awaddr;
              aw_held    <= 1'b1;
            end
            if (w_hs) begin
              wdata_reg <= control_wdata;
              w_held    <= 1'b1;
            end
            awready_reg <= ~(aw_held | aw_hs);
            wready_reg  <= ~(w_held | w_hs);
          end
        end
        W_RESP: begin
          if (control_bready) begin
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read channel: one outstanding read, data held until accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rdata_reg   <= rd_word;
            rresp_reg   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_state     <= R_DATA;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (control_rready) begin
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
            arready_reg <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign status_clr = (wr_fire && wr_idx == IDX_STATUS) ? wdata_reg[1:0] : 2'b00;

  // Register file update; an error level in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg     <= '0;
      seg_reg     <= '0;
      scratch_reg <= '0;
      status_reg  <= '0;
    end else begin
      status_reg <= (status_reg & ~status_clr) | {uart_error, flash_error};
      if (wr_fire) begin
        case (wr_idx)
          IDX_LED:     led_reg     <= wdata_reg[15:0];
          IDX_SEG:     seg_reg     <= wdata_reg[15:0];
          IDX_SCRATCH: scratch_reg <= wdata_reg;
          default:     ;
        endcase
      end
    end
  end

  assign control_awready = awready_reg;
  assign control_wready  = wready_reg;
  assign control_bvalid  = bvalid_reg;
  assign control_bresp   = bresp_reg;
  assign control_arready = arready_reg;
  assign control_rvalid  = rvalid_reg;
  assign control_rdata   = rdata_reg;
  assign control_rresp   = rresp_reg;
  assign led             = led_reg;
  assign seg_value       = seg_reg;

endmodule
